// File: rtl/aes128_core_iter_if.sv
// Stream and key-load interface of the iterative AES-128 core.
// The master side drives blocks and keys; the slave side is the core.
interface aes128_core_iter_if;
  logic         key_load;
  logic [127:0] key;
  logic [127:0] iv;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output key_load, key, iv, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  key_load, key, iv, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes128_core_iter.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock, round keys expanded
// on the fly from the base key, with optional CTR mode on a 32-bit wrapping counter.
module aes128_core_iter #(
  parameter int UNROLL = 1,
  parameter bit CTR_EN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  aes128_core_iter_if.slave bus
);

  // Byte x of the S-box sits at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State bytes are column-major: byte 4*c+r is row r of column c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] kreg_q, kreg_d;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] dreg_q, dreg_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mreg_q, mreg_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic         in_ready;
  logic         accept;
  logic         ctr_mode;
  logic [127:0] st_v, rk_v;
  logic [3:0]   r_v;
  logic         last_v;

  // A pending key load blocks acceptance so the next block sees the new key.
  assign in_ready = ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready)) && !bus.key_load;
  assign accept   = bus.in_valid && in_ready;
  assign ctr_mode = CTR_EN && bus.mode;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left one
    // unassigned would infer a latch.
    state_d     = state_q;
    kreg_d      = kreg_q;
    ctr_d       = ctr_q;
    st_d        = st_q;
    rk_d        = rk_q;
    dreg_d      = dreg_q;
    out_d       = out_q;
    rnd_d       = rnd_q;
    mreg_d      = mreg_q;
    out_valid_d = out_valid_q;

    // UNROLL chained rounds; rk_v tracks the key for the round just applied.
    st_v   = st_q;
    rk_v   = rk_q;
    r_v    = rnd_q;
    last_v = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      r_v  = rnd_q + 4'(i);
      rk_v = key_step(rk_v, rcon(r_v));
      st_v = sub_shift(st_v);
      if (r_v != 4'd10) st_v = mix_cols(st_v);
      st_v   = st_v ^ rk_v;
      last_v = (r_v == 4'd10);
    end

    case (state_q)
      IDLE: begin
        if (bus.key_load) begin
          kreg_d = bus.key;
          if (CTR_EN) ctr_d = bus.iv;
        end
      end
      RUN: begin
        st_d  = st_v;
        rk_d  = rk_v;
        rnd_d = rnd_q + 4'(UNROLL);
        if (last_v) begin
          state_d     = DONE;
          rnd_d       = 4'd10;
          out_valid_d = 1'b1;
          out_d       = mreg_q ? (st_v ^ dreg_q) : st_v;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (ctr_mode) begin
        st_d         = ctr_q ^ kreg_q;
        dreg_d       = bus.in_data;
        ctr_d[31:0]  = ctr_q[31:0] + 32'd1;
      end else begin
        st_d = bus.in_data ^ kreg_q;
      end
      rk_d    = kreg_q;
      rnd_d   = 4'd1;
      mreg_d  = ctr_mode;
      state_d = RUN;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kreg_q      <= '0;
      ctr_q       <= '0;
      st_q        <= '0;
      rk_q        <= '0;
      dreg_q      <= '0;
      out_q       <= '0;
      rnd_q       <= '0;
      mreg_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kreg_q      <= kreg_d;
      ctr_q       <= ctr_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      dreg_q      <= dreg_d;
      out_q       <= out_d;
      rnd_q       <= rnd_d;
      mreg_q      <= mreg_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes128_core_iter.sv
// Scoreboard bench for aes128_core_iter: four cores (UNROLL 1/2/5/10) driven from
// directed vectors; a negedge monitor checks latency, stability and data on retire.
module tb_aes128_core_iter;
  localparam int NI = 4;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] IV3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] B31 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] O31 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] B32 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] O32 = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] IVW = 128'h000000000000000000000000ffffffff;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] data;
    bit           chk;
    int           lat;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] key_load_s, mode_s, in_valid_s, out_ready_s;
  logic [NI-1:0] in_ready_s, out_valid_s, busy_s;
  logic [127:0]  key_s [NI];
  logic [127:0]  iv_s [NI];
  logic [127:0]  in_data_s [NI];
  logic [127:0]  out_data_s [NI];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_core_iter_if bus ();
    assign bus.key_load  = key_load_s[g];
    assign bus.key       = key_s[g];
    assign bus.iv        = iv_s[g];
    assign bus.mode      = mode_s[g];
    assign bus.in_valid  = in_valid_s[g];
    assign bus.in_data   = in_data_s[g];
    assign bus.out_ready = out_ready_s[g];
    assign in_ready_s[g]  = bus.in_ready;
    assign out_valid_s[g] = bus.out_valid;
    assign out_data_s[g]  = bus.out_data;
    assign busy_s[g]      = bus.busy;
    aes128_core_iter #(.UNROLL(U), .CTR_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 10 : (g == 1) ? 5 : (g == 2) ? 2 : 1;
  endfunction

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard queues and monitor state, one set per core.
  exp_t         exp_q [NI][$];
  bit           pending [NI];
  int           acc_cyc [NI];
  logic [127:0] held [NI];
  exp_t         mon_e;

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        pending[g] = 1'b0;
      end else begin
        if (out_valid_s[g]) begin
          if (exp_q[g].size() == 0) begin
            check_int($sformatf("u%0d_unexpected_out_valid", g), 1, 0);
          end else begin
            if (!pending[g]) begin
              pending[g] = 1'b1;
              held[g]    = out_data_s[g];
              check_int({exp_q[g][0].name, "_latency"}, cyc - acc_cyc[g], exp_q[g][0].lat);
            end else begin
              check128({exp_q[g][0].name, "_stable"}, out_data_s[g], held[g]);
            end
            if (out_ready_s[g]) begin
              mon_e = exp_q[g].pop_front();
              if (mon_e.chk) check128({mon_e.name, "_data"}, out_data_s[g], mon_e.data);
              pending[g] = 1'b0;
            end
          end
        end
        if (in_valid_s[g] && in_ready_s[g]) acc_cyc[g] = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int g, input logic [127:0] d, input bit chk, input int lat,
                          input string nm);
    exp_t e;
    e.data = d;
    e.chk  = chk;
    e.lat  = lat;
    e.name = nm;
    exp_q[g].push_back(e);
  endtask

  task automatic load_key(input int g, input logic [127:0] k, input logic [127:0] v);
    key_s[g]      = k;
    iv_s[g]       = v;
    key_load_s[g] = 1'b1;
    tick();
    key_load_s[g] = 1'b0;
  endtask

  task automatic send(input int g, input logic [127:0] d, input bit m, input logic [127:0] exp,
                      input bit chk, input int lat, input string nm, output int acc);
    push_exp(g, exp, chk, lat, nm);
    in_data_s[g]  = d;
    mode_s[g]     = m;
    in_valid_s[g] = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready_s[g]) acc = cyc + 1;
      tick();
    end
    in_valid_s[g] = 1'b0;
    if (acc < 0) check_int({nm, "_accept_timeout"}, 1, 0);
  endtask

  task automatic drain(input int g);
    int i;
    i = 0;
    while ((exp_q[g].size() != 0 || busy_s[g]) && i < 300) begin
      tick();
      i++;
    end
    if (i >= 300) check_int($sformatf("u%0d_drain_timeout", g), 1, 0);
  endtask

  initial begin
    int acc1, acc2;
    key_load_s  = '0;
    mode_s      = '0;
    in_valid_s  = '0;
    out_ready_s = '1;
    for (int g = 0; g < NI; g++) begin
      key_s[g]     = '0;
      iv_s[g]      = '0;
      in_data_s[g] = '0;
    end

    // Reset state, then release away from the clock edge.
    #12;
    for (int g = 0; g < NI; g++) begin
      check_int($sformatf("u%0d_rst_out_valid", g), int'(out_valid_s[g]), 0);
      check_int($sformatf("u%0d_rst_busy", g), int'(busy_s[g]), 0);
      check128($sformatf("u%0d_rst_out_data", g), out_data_s[g], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) check_int($sformatf("u%0d_in_ready_after_rst", g), int'(in_ready_s[g]), 1);
    tick();

    // FIPS-197 C.1 on the one-round-per-cycle core.
    load_key(0, K1, '0);
    send(0, P1, 1'b0, C1, 1'b1, 10, "ecb_c1", acc1);
    drain(0);

    // FIPS-197 appendix B vector on every unroll factor.
    for (int g = 0; g < NI; g++) begin
      load_key(g, K2, '0);
      send(g, P2, 1'b0, C2, 1'b1, lat_of(g), $sformatf("ecb_b_u%0d", g), acc1);
      drain(g);
    end

    // Backpressure: block A waits in DONE, block B waits at the input, key_load pulses.
    out_ready_s[0] = 1'b0;
    send(0, P2, 1'b0, C2, 1'b1, 10, "bp_a", acc1);
    push_exp(0, C2, 1'b1, 10, "bp_b");
    in_data_s[0]  = P2;
    mode_s[0]     = 1'b0;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 50 && !out_valid_s[0]; i++) tick();
    check_int("bp_out_valid_high", int'(out_valid_s[0]), 1);
    for (int k = 0; k < 20; k++) begin
      key_load_s[0] = (k >= 5 && k <= 7);
      key_s[0]      = '0;
      @(negedge clk);
      check_int("bp_in_ready_low", int'(in_ready_s[0]), 0);
      tick();
    end
    key_load_s[0]  = 1'b0;
    key_s[0]       = K2;
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    check_int("bp_in_ready_on_retire", int'(in_ready_s[0]), 1);
    tick();
    in_valid_s[0] = 1'b0;
    check_int("bp_b_running", int'(busy_s[0]), 1);
    check_int("bp_out_valid_dropped", int'(out_valid_s[0]), 0);
    drain(0);

    // CTR, SP800-38A F.5.1, back to back.
    load_key(0, K2, IV3);
    send(0, B31, 1'b1, O31, 1'b1, 10, "ctr_b1", acc1);
    send(0, B32, 1'b1, O32, 1'b1, 10, "ctr_b2", acc2);
    check_int("ctr_b2b_spacing", acc2 - acc1, 11);
    drain(0);

    // Counter wrap under the all-zero key; second counter block is 0...0.
    load_key(0, '0, IVW);
    send(0, '0, 1'b1, '0, 1'b0, 10, "wrap_b1", acc1);
    send(0, '0, 1'b1, CZ, 1'b1, 10, "wrap_b2", acc2);
    send(0, '0, 1'b0, CZ, 1'b1, 10, "ecb_zero", acc1);
    drain(0);

    // Mid-RUN reset discards the block with no partial output.
    load_key(0, K1, '0);
    send(0, P1, 1'b0, C1, 1'b1, 10, "rst_victim", acc1);
    tick();
    tick();
    tick();
    check_int("mid_run_busy", int'(busy_s[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("mid_rst_out_valid", int'(out_valid_s[0]), 0);
    check_int("mid_rst_busy", int'(busy_s[0]), 0);
    check128("mid_rst_out_data", out_data_s[0], '0);
    exp_q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_int("mid_rst_in_ready", int'(in_ready_s[0]), 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_int("post_rst_no_out_valid", int'(out_valid_s[0]), 0);
    end
    tick();

    // key_load and in_valid together in IDLE: key wins, block follows under it.
    push_exp(0, C1, 1'b1, 10, "load_prio");
    key_s[0]      = K1;
    key_load_s[0] = 1'b1;
    in_data_s[0]  = P1;
    mode_s[0]     = 1'b0;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    check_int("load_prio_in_ready_low", int'(in_ready_s[0]), 0);
    tick();
    key_load_s[0] = 1'b0;
    @(negedge clk);
    check_int("load_prio_in_ready_high", int'(in_ready_s[0]), 1);
    tick();
    in_valid_s[0] = 1'b0;
    drain(0);

    for (int g = 0; g < NI; g++) drain(g);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes128_core_iter.md
# aes128_core_iter

Iterative, parametrised AES-128 encryption core with on-the-fly key expansion, a valid/ready stream interface and an optional CTR mode. It is the next-generation encryption datapath of the AES block: it generates round keys on the fly instead of holding a 1408-bit expanded-key bus. Rounds per cycle are set by a parameter, so one RTL serves both small and fast builds. The core uses the team's existing S-box and MixColumns functions.

## Interface
- `UNROLL`, default 1: rounds computed per clock; legal values 1, 2, 5, 10. Define N = 10/UNROLL.
- `CTR_EN`, default 1: 1 builds the CTR counter and the `mode` input; 0 builds ECB only.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_load` in 1: load pulse for `key` and, when `CTR_EN`=1, for `iv`.
- `key` in 128: cipher key, FIPS-197 byte order (byte 0 in bits 127:120).
- `iv` in 128: initial counter block, CTR only.
- `mode` in 1: 0 selects ECB, 1 selects CTR. Ignored when `CTR_EN`=0.
- `in_valid` / `in_ready` in/out 1: input handshake.
- `in_data` in 128: plaintext block.
- `out_valid` / `out_ready` out/in 1: output handshake.
- `out_data` out 128: ciphertext block.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Registers:
  - base key `kreg`
  - counter `ctr` (when `CTR_EN`=1)
  - AES state `st`
  - current round key `rk`
  - round counter `rnd` (0..10)
  - held data `dreg` (CTR only)
  - latched mode `mreg`
- FSM has three states: IDLE, RUN, DONE.
- Key load:
  - `key_load`=1 in IDLE loads `kreg`<=`key` and `ctr`<=`iv`.
  - `key_load` in RUN or DONE is ignored.
- `in_ready` = (IDLE or (DONE and `out_ready`)) and not `key_load`. Key load therefore wins over a simultaneous block.
- Accept (`in_valid` and `in_ready`):
  - ECB: `st`<=`in_data` XOR `kreg`.
  - CTR: `st`<=`ctr` XOR `kreg`, `dreg`<=`in_data`, and `ctr[31:0]`<=`ctr[31:0]`+1 mod 2^32. `ctr[127:32]` never changes.
  - All modes: `rk`<=`kreg`, `rnd`<=1, `mreg`<=`mode`, state goes to RUN.
- RUN:
  - Each cycle applies UNROLL rounds, updating `rk` by key expansion with Rcon[rnd].
  - Rounds 1..9 are SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10 omits MixColumns.
  - When round 10 completes, go to DONE.
- DONE:
  - `out_valid`=1 and `out_data` holds stable: `st` in ECB, `st` XOR `dreg` in CTR.
  - `out_ready`=1 retires the block. If `in_valid` is also high, the next block is accepted on the same edge and the state goes to RUN; otherwise it goes to IDLE.
- Backpressure: DONE holds indefinitely with outputs unchanged while `out_ready`=0.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `out_valid`, `busy`, `out_data`, `kreg`, `ctr`, `st` and `rnd` all go to 0.
  - `in_ready` becomes 1 once the reset releases (with `key_load` low).
  - An in-flight block is discarded; no partial output appears.

## Timing
- Latency: `out_valid` rises N cycles after the accept edge (10 for UNROLL=1, 1 for UNROLL=10).
- Throughput: one block per N+1 cycles when `out_ready` is held high.
- `out_data` is registered. `in_ready` is combinational from state, `out_ready` and `key_load`.
- After a `key_load` edge, the new key takes effect for the block accepted on the next cycle.
- Counter wrap: `ctr[31:0]`=FFFFFFFF goes to 00000000 with no flag and the upper 96 bits unchanged.

## Test plan
- Test 1, ECB, FIPS-197 C.1 vector, UNROLL=1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a, and `out_valid` exactly 10 cycles after accept.
- Test 2, ECB, FIPS-197 B vector, repeated for UNROLL=2/5/10:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: 3925841d02dc09fbdc118597196a0b32 at latency 5/2/1.
- Test 3, CTR, SP800-38A F.5.1 (same key as test 2):
  - Stimulus: iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; blocks 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51, sent back to back with `out_ready`=1.
  - Required: outputs 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff, and the second block accepted on the retire edge.
- Test 4, backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles in DONE while `in_valid`=1.
  - Required: `in_ready`=0, `out_data` stable, `key_load` ignored; the block retires on the first cycle `out_ready`=1.
- Test 5, counter wrap:
  - Stimulus: iv 000000000000000000000000ffffffff, then two CTR blocks of all-zero data.
  - Required: the second output equals the ECB encryption of 0…0 (the counter after wrap, upper 96 bits unchanged).
- Test 6, reset and load priority:
  - Stimulus: assert `rst_n`=0 in mid-RUN; separately, assert `key_load` and `in_valid` together in IDLE.
  - Required: after the mid-RUN reset, all outputs go to 0 immediately and no `out_valid` follows. For the simultaneous case, the key loads, `in_ready`=0 that cycle, and the block is accepted the next cycle under the new key.
